// File: rtl/mc10_pkg.sv
// rtl/mc10_pkg.sv - shared types and constants for the MC-10 RAM arbiter
// Purpose : FSM state and owner enums, request-vector bit positions and the
//           default RAM address width.
// Ports   : none (package).
package mc10_pkg;

    localparam int MC10_ADDR_W = 15;

    // Bit positions inside the request / ignore vectors handed to the picker.
    localparam int REQ_VID = 0;
    localparam int REQ_CPU = 1;
    localparam int REQ_LDR = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LATCH  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2,
        LDR  = 2'd3
    } arb_owner_t;

endpackage

// File: rtl/mc10_arb_pick.sv
// rtl/mc10_arb_pick.sv - combinational fixed-priority picker with starvation override
// Purpose : chooses the next RAM owner from the eligible requesters.
// Ports   : req[2:0]    - request vector {ldr, cpu, vid}
//           ignore_mask - requesters acked this cycle, excluded from the pick
//           starve_sat  - loader starvation counter saturated
//           owner       - winning owner, NONE when nothing is eligible
module mc10_arb_pick
    import mc10_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] ignore_mask,
    input  logic       starve_sat,
    output arb_owner_t owner
);

    logic [2:0] elig;

    assign elig = req & ~ignore_mask;

    always_comb begin
        owner = NONE;
        if (elig[REQ_VID]) begin
            owner = VID;
        end else if (elig[REQ_LDR] && starve_sat) begin
            owner = LDR;
        end else if (elig[REQ_CPU]) begin
            owner = CPU;
        end else if (elig[REQ_LDR]) begin
            owner = LDR;
        end
    end

endmodule

// File: rtl/mc10_ram_arbiter.sv
// rtl/mc10_ram_arbiter.sv - single-port RAM arbiter for VDG, 6803 CPU and HPS loader
// Purpose : grants the shared RAM to one requester at a time through an
//           IDLE -> ACCESS -> LATCH sequence (one access per 3 cycles).
// Config  : MC10_ARB_LOADER_EN enables the loader port and starvation guard;
//           when undefined ldr_req is ignored and ldr_ack stays 0.
// Ports   : clk_sys, reset_n (async, active low)
//           vid_req/vid_addr -> vid_ack/vid_data            (video reads)
//           cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_rdata
//           ldr_req/ldr_addr/ldr_wdata -> ldr_ack           (loader writes)
//           ram_en/ram_we/ram_addr/ram_wdata, ram_rdata     (RAM macro)
module mc10_ram_arbiter
    import mc10_pkg::*;
#(
    parameter int ADDR_W     = MC10_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic              ldr_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    arb_state_t state, state_nxt;
    arb_owner_t owner, pick;
    logic       acc_we;
    logic       ldr_ack_q;
    logic       ldr_eff;
    logic       starve_sat;

`ifdef MC10_ARB_LOADER_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign ldr_eff    = ldr_req;
    assign ldr_ack    = ldr_ack_q;
    assign starve_sat = (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts CPU wins taken while the loader was waiting; any loader grant
    // starts the count over.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick == LDR) begin
                starve_cnt <= '0;
            end else if (pick == CPU && ldr_req && !starve_sat) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_starve_max = STARVE_MAX;

    logic unused_ldr;

    assign ldr_eff    = 1'b0;
    assign ldr_ack    = 1'b0;
    assign starve_sat = 1'b0;
    assign unused_ldr = ^{ldr_req, ldr_ack_q};
`endif

    // Acks double as the ignore mask: a requester still holding req in its
    // ack cycle must not be granted a second time.
    mc10_arb_pick u_pick (
        .req         ({ldr_eff, cpu_req, vid_req}),
        .ignore_mask ({ldr_ack_q, cpu_ack, vid_ack}),
        .starve_sat  (starve_sat),
        .owner       (pick)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick != NONE) state_nxt = ACCESS;
            ACCESS:  state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= NONE;
            acc_we    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack_q <= 1'b0;
            vid_data  <= '0;
            cpu_rdata <= '0;
        end else begin
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick != NONE) begin
                        owner  <= pick;
                        ram_en <= 1'b1;
                        case (pick)
                            VID: begin
                                ram_we   <= 1'b0;
                                acc_we   <= 1'b0;
                                ram_addr <= vid_addr;
                            end
                            CPU: begin
                                ram_we    <= cpu_we;
                                acc_we    <= cpu_we;
                                ram_addr  <= cpu_addr;
                                ram_wdata <= cpu_wdata;
                            end
                            default: begin
                                ram_we    <= 1'b1;
                                acc_we    <= 1'b1;
                                ram_addr  <= ldr_addr;
                                ram_wdata <= ldr_wdata;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                end
                LATCH: begin
                    owner <= NONE;
                    case (owner)
                        VID: begin
                            vid_ack  <= 1'b1;
                            vid_data <= ram_rdata;
                        end
                        CPU: begin
                            cpu_ack <= 1'b1;
                            if (!acc_we) cpu_rdata <= ram_rdata;
                        end
                        LDR:     ldr_ack_q <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc10_ram_arbiter.sv
// tb/tb_mc10_ram_arbiter.sv - directed self-checking bench for mc10_ram_arbiter
module tb_mc10_ram_arbiter;

    localparam int ADDR_W = 15;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              vid_req, cpu_req, cpu_we, ldr_req;
    logic [ADDR_W-1:0] vid_addr, cpu_addr, ldr_addr;
    logic [7:0]        cpu_wdata, ldr_wdata;
    logic              vid_ack, cpu_ack, ldr_ack;
    logic [7:0]        vid_data, cpu_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata = 8'h00;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    mc10_ram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ack   (vid_ack),
        .vid_data  (vid_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ldr_req   (ldr_req),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous single-port RAM: read data valid the cycle after ram_en.
    always @(posedge clk_sys) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] = ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

`ifdef MC10_ARB_LOADER_EN
    logic [7:0] got_seq [12];
    string      exp_seq = "VCVCVCVCVLVC";
    int         n_got;
`endif

    initial begin
        reset_n = 1'b0;
        vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ldr_req = 1'b0;
        vid_addr = '0; cpu_addr = '0; ldr_addr = '0;
        cpu_wdata = '0; ldr_wdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;

        // Reset state
        tick(2);
        check("rst_ram_en",    32'(ram_en), 0);
        check("rst_ram_we",    32'(ram_we), 0);
        check("rst_ram_addr",  32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_acks",      32'({vid_ack, cpu_ack, ldr_ack}), 0);
        check("rst_vid_data",  32'(vid_data), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        reset_n = 1'b1;
        tick();

        // CPU read of 0x1234 holding 0x5A
        mem[15'h1234] = 8'h5A;
        cpu_addr = 15'h1234; cpu_we = 1'b0; cpu_req = 1'b1;
        tick();
        check("rd_en_n1",   32'(ram_en), 1);
        check("rd_we_n1",   32'(ram_we), 0);
        check("rd_addr_n1", 32'(ram_addr), 'h1234);
        tick();
        check("rd_en_n2",   32'(ram_en), 0);
        check("rd_ack_n2",  32'(cpu_ack), 0);
        tick();
        check("rd_ack_n3",  32'(cpu_ack), 1);
        check("rd_data_n3", 32'(cpu_rdata), 'h5A);
        cpu_req = 1'b0;
        tick();
        check("rd_ack_n4",  32'(cpu_ack), 0);
        check("rd_hold_n4", 32'(cpu_rdata), 'h5A);

        // VID and CPU rise together: video first, CPU three cycles later
        mem[15'h0100] = 8'h11; mem[15'h0200] = 8'h22;
        vid_addr = 15'h0100; cpu_addr = 15'h0200;
        vid_req = 1'b1; cpu_req = 1'b1;
        tick();
        check("vc_addr_n1", 32'(ram_addr), 'h0100);
        tick(2);
        check("vc_vack_n3", 32'(vid_ack), 1);
        check("vc_vdat_n3", 32'(vid_data), 'h11);
        check("vc_cack_n3", 32'(cpu_ack), 0);
        vid_req = 1'b0;
        tick();
        check("vc_en_n4",   32'(ram_en), 1);
        check("vc_addr_n4", 32'(ram_addr), 'h0200);
        tick(2);
        check("vc_cack_n6", 32'(cpu_ack), 1);
        check("vc_cdat_n6", 32'(cpu_rdata), 'h22);
        cpu_req = 1'b0;
        tick();

        // CPU write leaves cpu_rdata alone, then read it back
        cpu_addr = 15'h0300; cpu_wdata = 8'h3C; cpu_we = 1'b1; cpu_req = 1'b1;
        tick();
        check("wr_we_n1",   32'(ram_we), 1);
        check("wr_wd_n1",   32'(ram_wdata), 'h3C);
        tick(2);
        check("wr_ack_n3",  32'(cpu_ack), 1);
        check("wr_rdata",   32'(cpu_rdata), 'h22);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        cpu_req = 1'b1;
        tick(3);
        check("wr_rb_ack",  32'(cpu_ack), 1);
        check("wr_rb_data", 32'(cpu_rdata), 'h3C);
        cpu_req = 1'b0;
        tick();

        // Requester keeps req through its ack: other one granted, no duplicate
        mem[15'h0400] = 8'h44; mem[15'h0500] = 8'h55;
        cpu_addr = 15'h0400; cpu_req = 1'b1;
        tick();
        vid_addr = 15'h0500; vid_req = 1'b1;
        tick(2);
        check("nd_cack_n3", 32'(cpu_ack), 1);
        check("nd_cdat_n3", 32'(cpu_rdata), 'h44);
        tick();
        check("nd_en_n4",   32'(ram_en), 1);
        check("nd_addr_n4", 32'(ram_addr), 'h0500);
        cpu_req = 1'b0;
        tick(2);
        check("nd_vack_n6", 32'(vid_ack), 1);
        check("nd_vdat_n6", 32'(vid_data), 'h55);
        check("nd_cack_n6", 32'(cpu_ack), 0);
        tick();
        check("nd_en_n7",   32'(ram_en), 0);
        check("nd_vack_n7", 32'(vid_ack), 0);
        vid_req = 1'b0;
        tick(2);

`ifdef MC10_ARB_LOADER_EN
        // Loader write 0xA5 to 0x4000, CPU reads it back
        ldr_addr = 15'h4000; ldr_wdata = 8'hA5; ldr_req = 1'b1;
        tick();
        check("ld_we_n1",   32'(ram_we), 1);
        check("ld_addr_n1", 32'(ram_addr), 'h4000);
        check("ld_wd_n1",   32'(ram_wdata), 'hA5);
        tick(2);
        check("ld_ack_n3",  32'(ldr_ack), 1);
        ldr_req = 1'b0;
        tick();
        cpu_addr = 15'h4000; cpu_req = 1'b1;
        tick(3);
        check("ld_rb_ack",  32'(cpu_ack), 1);
        check("ld_rb_data", 32'(cpu_rdata), 'hA5);
        cpu_req = 1'b0;
        tick();

        // Starvation: all three held; four contested CPU wins, then LDR
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        vid_req = 1'b1; cpu_req = 1'b1; ldr_req = 1'b1;
        n_got = 0;
        for (int c = 0; c < 60 && n_got < 12; c++) begin
            tick();
            if (vid_ack) begin got_seq[n_got] = "V"; n_got++; end
            else if (cpu_ack) begin got_seq[n_got] = "C"; n_got++; end
            else if (ldr_ack) begin got_seq[n_got] = "L"; n_got++; end
        end
        check("sv_count", 32'(n_got), 12);
        for (int i = 0; i < n_got; i++) begin
            check($sformatf("sv_grant%0d", i), 32'(got_seq[i]), 32'(exp_seq[i]));
        end
        vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        tick(6);
`else
        // Loader port disabled: ldr_req never produces an access or ack
        ldr_addr = 15'h0010; ldr_wdata = 8'h77; ldr_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("lo_en%0d", c),  32'(ram_en), 0);
            check($sformatf("lo_ack%0d", c), 32'(ldr_ack), 0);
        end
        ldr_req = 1'b0;
        tick();
`endif

        // Reset while a CPU write is in ACCESS
        mem[15'h0600] = 8'h01;
        cpu_addr = 15'h0600; cpu_wdata = 8'hEE; cpu_we = 1'b1; cpu_req = 1'b1;
        tick();
        check("ra_we_pre", 32'(ram_we), 1);
        #1;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        check("ra_we",     32'(ram_we), 0);
        check("ra_en",     32'(ram_en), 0);
        check("ra_addr",   32'(ram_addr), 0);
        check("ra_wdata",  32'(ram_wdata), 0);
        check("ra_cdata",  32'(cpu_rdata), 0);
        check("ra_vdata",  32'(vid_data), 0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("ra_cack%0d", c), 32'(cpu_ack), 0);
        end
        check("ra_mem", 32'(mem[15'h0600]), 'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
